// File: rtl/delay_arb_pkg.sv
// Shared constants, index-width helper and tag record for delay_line_arbiter.
package delay_arb_pkg;

    localparam int DEFAULT_NUM_REQ = 4;
    localparam int DEFAULT_DELAY   = 3;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Sized for the largest supported requester count so one record type fits every build.
    localparam int TAG_IDX_W = idx_width(8);

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Single-grant arbiter: round-robin by default, fixed lowest-index priority
// when DELAY_ARB_FIXED_PRI_EN is defined.
module rr_arbiter
    import delay_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

`ifdef DELAY_ARB_FIXED_PRI_EN

    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_idx = IDX_W'(i);
                grant_vld = 1'b1;
            end
        end
    end

`else

    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Scan upward from the pointer, wrapping at NUM_REQ rather than 2**IDX_W.
    always_comb begin
        logic [IDX_W-1:0] cand;
        int               c;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = '0;
        c         = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            c = int'(ptr_q) + off;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            cand = IDX_W'(c);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

`endif

endmodule

// File: rtl/delay_line_arbiter.sv
// Time-shares one external fixed-latency delay unit among NUM_REQ requesters,
// tagging each bit so it returns to its owner. Build option: DELAY_ARB_FIXED_PRI_EN.
module delay_line_arbiter
    import delay_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int DELAY   = DEFAULT_DELAY,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] d_in,
    output logic [NUM_REQ-1:0] grant,
    output logic               line_d,
    input  logic               line_q,
    output logic [NUM_REQ-1:0] out_valid,
    output logic [NUM_REQ-1:0] out_d,
    output logic               busy
);

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [IDX_W-1:0]   arb_idx;
    logic               arb_vld;

    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               line_d_q, line_d_d;
    tag_t               issue_q, issue_d;
    tag_t               tag_q [DELAY];
    tag_t               tail;
    logic [NUM_REQ-1:0] out_valid_q, out_valid_d;
    logic [NUM_REQ-1:0] out_d_q, out_d_d;
    logic               busy_q, busy_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    // issue_q travels with line_d; tag_q[k] then tracks the external shift
    // register, so the last stage is valid exactly when line_q carries that bit.
    always_comb begin
        grant_d  = arb_vld ? (ONE << arb_idx) : '0;
        line_d_d = arb_vld & d_in[arb_idx];
        issue_d  = '0;
        if (arb_vld) begin
            issue_d.valid = 1'b1;
            issue_d.idx   = TAG_IDX_W'(arb_idx);
        end

        tail        = tag_q[DELAY-1];
        out_valid_d = tail.valid ? (ONE << tail.idx) : '0;
        out_d_d     = line_q ? out_valid_d : '0;

        busy_d = issue_q.valid;
        for (int s = 0; s < DELAY - 1; s++) begin
            busy_d = busy_d | tag_q[s].valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q     <= '0;
            line_d_q    <= 1'b0;
            issue_q     <= '0;
            out_valid_q <= '0;
            out_d_q     <= '0;
            busy_q      <= 1'b0;
            for (int s = 0; s < DELAY; s++) tag_q[s] <= '0;
        end else begin
            grant_q     <= grant_d;
            line_d_q    <= line_d_d;
            issue_q     <= issue_d;
            out_valid_q <= out_valid_d;
            out_d_q     <= out_d_d;
            busy_q      <= busy_d;
            tag_q[0]    <= issue_q;
            for (int s = 1; s < DELAY; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    assign grant     = grant_q;
    assign line_d    = line_d_q;
    assign out_valid = out_valid_q;
    assign out_d     = out_d_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_delay_line_arbiter.sv
// Scoreboard bench for delay_line_arbiter with a behavioural 3-cycle delay unit;
// expectations adapt when DELAY_ARB_FIXED_PRI_EN is defined.
module tb_delay_line_arbiter;

`ifdef DELAY_ARB_FIXED_PRI_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d_in;
    logic [3:0] grant;
    logic       line_d;
    logic       line_q;
    logic [3:0] out_valid;
    logic [3:0] out_d;
    logic       busy;

    logic [2:0] dl = '0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int   idx;
        logic d;
        int   cyc;
    } exp_t;

    exp_t expQ[$];

    delay_line_arbiter #(
        .NUM_REQ (4),
        .DELAY   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d_in      (d_in),
        .grant     (grant),
        .line_d    (line_d),
        .line_q    (line_q),
        .out_valid (out_valid),
        .out_d     (out_d),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External delay unit: three-register shift path with no reset.
    always @(posedge clk) dl <= {dl[1:0], line_d};
    assign line_q = dl[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every return pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid != 4'b0) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_return", {28'b0, out_valid}, 32'h0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("ret_valid", {28'b0, out_valid}, 32'(1 << e.idx));
                    checkOutput("ret_data", {28'b0, out_d}, e.d ? 32'(1 << e.idx) : 32'h0);
                    checkOutput("ret_cycle", cyc, e.cyc);
                end
            end else if (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("missing_return", {28'b0, out_valid}, 32'(1 << e.idx));
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d, input int win);
        logic [3:0] dv;
        dv   = d;
        req  = r;
        d_in = d;
        if (win >= 0) expQ.push_back('{win, dv[win], cyc + 5});
        @(posedge clk);
        @(negedge clk);
        checkOutput("grant", {28'b0, grant}, win >= 0 ? 32'(1 << win) : 32'h0);
        checkOutput("line_d", {31'b0, line_d}, win >= 0 ? {31'b0, dv[win]} : 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(4'b0000, 4'b0000, -1);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        d_in  = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_grant", {28'b0, grant}, 32'h0);
        checkOutput("rst_line_d", {31'b0, line_d}, 32'h0);
        checkOutput("rst_out_valid", {28'b0, out_valid}, 32'h0);
        checkOutput("rst_out_d", {28'b0, out_d}, 32'h0);
        checkOutput("rst_busy", {31'b0, busy}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] all requesters held for four cycles");
        applyStimulus(4'b1111, 4'b1010, 0);
        checkOutput("rr_busy_c1", {31'b0, busy}, 32'h0);
        applyStimulus(4'b1111, 4'b1010, FIXED ? 0 : 1);
        checkOutput("rr_busy_c2", {31'b0, busy}, 32'h1);
        applyStimulus(4'b1111, 4'b1010, FIXED ? 0 : 2);
        applyStimulus(4'b1111, 4'b1010, FIXED ? 0 : 3);
        for (int c = 5; c <= 8; c++) begin
            applyStimulus(4'b0000, 4'b0000, -1);
            checkOutput("rr_busy_tail", {31'b0, busy}, (c <= 7) ? 32'h1 : 32'h0);
        end

        $display("[TB] single request from requester 1");
        applyStimulus(4'b0010, 4'b0010, 1);
        applyStimulus(4'b0000, 4'b0000, -1);
        checkOutput("single_busy", {31'b0, busy}, 32'h1);
        idle(4);

        $display("[TB] wrap and skip from pointer 3");
        applyStimulus(4'b0100, 4'b0100, 2);
        applyStimulus(4'b0101, 4'b0001, 0);
        applyStimulus(4'b0101, 4'b0001, FIXED ? 0 : 2);
        applyStimulus(4'b1001, 4'b1000, FIXED ? 0 : 3);

        $display("[TB] two requesters held for three cycles");
        applyStimulus(4'b0011, 4'b0011, 0);
        applyStimulus(4'b0011, 4'b0011, FIXED ? 0 : 1);
        applyStimulus(4'b0011, 4'b0011, 0);
        applyStimulus(4'b0010, 4'b0000, 1);
        idle(6);

        $display("[TB] reset with bits in flight");
        applyStimulus(4'b0001, 4'b0001, 0);
        applyStimulus(4'b0100, 4'b0100, 2);
        rst_n = 1'b0;
        req   = '0;
        d_in  = '0;
        expQ.delete();
        #1;
        checkOutput("midrst_grant", {28'b0, grant}, 32'h0);
        checkOutput("midrst_line_d", {31'b0, line_d}, 32'h0);
        checkOutput("midrst_busy", {31'b0, busy}, 32'h0);
        checkOutput("midrst_out_valid", {28'b0, out_valid}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(6);

        $display("[TB] highest index after reset");
        applyStimulus(4'b1000, 4'b1000, 3);
        idle(6);

        checkOutput("queue_drained", expQ.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/delay_line_arbiter.md
Name: delay_line_arbiter

Overview:
- Shares one external fixed-latency D_signal_delay unit (3-cycle shift path) among NUM_REQ requesters.
- Grants one requester per cycle and drives that requester's data bit into the shared line.
- Carries a requester tag alongside the line so each delayed bit comes back to its owner.
- Sits between the input-sampling logic and the shared delay unit.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DELAY, 3: latency of the external delay unit in clk edges, from line_d sampled to line_q valid; ≥1.
- IDX_W, 2: requester index width, ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request level; a set bit means requester i has a bit to send
- d_in  in  NUM_REQ  per-requester data bit, sampled with req
- grant  out  NUM_REQ  one-hot grant pulse, registered
- line_d  out  1  data to the shared delay unit's D input, registered
- line_q  in  1  delayed data from the delay unit's D_o output
- out_valid  out  NUM_REQ  one-hot return pulse, registered
- out_d  out  NUM_REQ  returned delayed bit; only bit i with out_valid[i]=1 is meaningful, all others 0
- busy  out  1  1 while any tag stage is valid

Behaviour:
- Reset (async, rst_n=0): grant=0, line_d=0, out_valid=0, out_d=0, busy=0, RR pointer=0, all tag stages invalid.
  - A reset mid-flight discards every in-flight bit; no out_valid pulse is ever produced for it.
- Arbitration, at every edge with req≠0:
  - Search from pointer upward with wrap-around; the first set req bit i wins.
  - Next cycle: grant=onehot(i), line_d=d_in[i] as sampled, tag stage 0 ← {valid=1, idx=i}.
  - Pointer ← (i+1) mod NUM_REQ.
  - At most one grant per cycle.
- Idle: when req=0, grant=0, line_d=0, tag stage 0 invalid, pointer unchanged.
- Handshake:
  - grant is a single-cycle pulse.
  - A requester that keeps req high after its grant is treated as issuing a new request and competes again under round-robin.
  - Requesters drop req in the cycle grant is seen if they have nothing further to send.
- Tag pipeline: DELAY stages, shifted every cycle unconditionally, so it stays aligned with the external shift path.
- Return:
  - When tag stage DELAY-1 is valid with idx=k, at the next edge out_valid=onehot(k) and out_d[k]=line_q.
  - Otherwise out_valid=0 and out_d=0.
- Latency:
  - req sampled at edge t → grant/line_d at t+1 → line_q valid at t+1+DELAY → out_valid at t+2+DELAY.
  - Request to return is DELAY+2 cycles; default 5.
- Throughput: one bit per cycle sustained. A grant and a return to the same or different requesters in the same cycle are independent and both occur.
- busy = OR of all tag-stage valid bits, registered with the stages.
- NUM_REQ not a power of two: the pointer wraps at NUM_REQ; index values ≥NUM_REQ never occur.

Optional Feature:
- Macro: DELAY_ARB_FIXED_PRI_EN.
- Defined: fixed priority; lowest set req index always wins; pointer logic removed.
- Undefined: round-robin as above.
- Latency, tag pipeline and return path are identical in both builds.

Decomposition:
- Package delay_arb_pkg holds:
  - default NUM_REQ/DELAY constants
  - IDX_W derivation function
  - tag stage record: valid bit + IDX_W index
- Sub-module rr_arbiter:
  - ports: clk, rst_n, req, grant_idx, grant_vld
  - contains the pointer and the DELAY_ARB_FIXED_PRI_EN variant
  - top level holds the tag pipeline and return registers

Test Plan:
- Single request: req=4'b0010, d_in[1]=1 for one cycle at edge 0 → grant=4'b0010 at cycle 1, line_d=1 at cycle 1, out_valid=4'b0010 with out_d[1]=1 at cycle 5.
- Round-robin: req=4'b1111 held 4 cycles, d_in=4'b1010 → grants 0,1,2,3 in cycles 1..4; out_valid for 0,1,2,3 in cycles 5..8; out_d values 0,1,0,1; busy high in cycles 2..7.
- Wrap and skip: pointer=3, req=4'b0101 → grant idx 0 first, then 2; pointer ends at 3.
- Reset mid-flight: grants issued in cycles 1 and 2, rst_n=0 in cycle 3 → no out_valid pulses afterwards; all outputs 0 immediately (async); busy=0.
- Model-driven stream: random req/d_in for 1000 cycles against a behavioural 3-cycle delay model → every grant matched by exactly one return to the same index, DELAY+1 cycles later, with equal data; never two out_valid bits set.
- DELAY_ARB_FIXED_PRI_EN defined: req=4'b0011 held 3 cycles → grant idx 0 every cycle; idx 1 starved until req[0] drops.
